// File: rtl/share_pkg.sv
// ============================================================================
// share_pkg : shared types and constants for the share_div_seq datapath
// Revision  : 1.0
// ============================================================================
`default_nettype none

package share_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CMP_THRESH = 8;
  localparam int unsigned DIV_ITERS  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage : share_pkg

`default_nettype wire

// File: rtl/share_div_core.sv
// ============================================================================
// share_div_core : iterative restoring divider, one quotient bit per step.
// Optional remainder output under SHARE_DIV_REM_EN.  Revision : 1.0
// ============================================================================
`default_nettype none

module share_div_core
  import share_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              done_o,
  output logic [DATA_W-1:0] quo_o
`ifdef SHARE_DIV_REM_EN
  ,
  output logic [DATA_W-1:0] rem_o
`endif
);

  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] yres_q, yres_d;
`ifdef SHARE_DIV_REM_EN
  logic [DATA_W-1:0] rres_q, rres_d;
`endif

  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;
  logic              ge;
  logic              last;

  always_comb begin
    shifted = {rem_q, quo_q[DATA_W-1]};
    ge      = (shifted >= {1'b0, dvs_q});
    // When ge holds the true difference is below the divisor, so the
    // modulo-256 subtraction of the low bits is exact.
    diff    = shifted[DATA_W-1:0] - dvs_q;
    last    = step_i && (cnt_q == 3'(DIV_ITERS - 1));

    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    yres_d = yres_q;
`ifdef SHARE_DIV_REM_EN
    rres_d = rres_q;
`endif

    if (load_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
      cnt_d = '0;
    end else if (step_i) begin
      if (ge) begin
        rem_d = diff;
        quo_d = {quo_q[DATA_W-2:0], 1'b1};
      end else begin
        rem_d = shifted[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], 1'b0};
      end
      cnt_d = cnt_q + 3'd1;
      if (last) begin
        yres_d = quo_d;
`ifdef SHARE_DIV_REM_EN
        rres_d = rem_d;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      yres_q <= '0;
`ifdef SHARE_DIV_REM_EN
      rres_q <= '0;
`endif
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      yres_q <= yres_d;
`ifdef SHARE_DIV_REM_EN
      rres_q <= rres_d;
`endif
    end
  end

  assign done_o = last;
  assign quo_o  = yres_q;
`ifdef SHARE_DIV_REM_EN
  assign rem_o  = rres_q;
`endif

endmodule : share_div_core

`default_nettype wire

// File: rtl/share_div_seq.sv
// ============================================================================
// share_div_seq : operand select on a shared multiplier, then shared divide.
// Port r present only with SHARE_DIV_REM_EN.  Revision : 1.0
// ============================================================================
`default_nettype none

module share_div_seq
  import share_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              s,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y
`ifdef SHARE_DIV_REM_EN
  ,
  output logic [DATA_W-1:0] r
`endif
);

  state_e state_q, state_d;

  logic              s_q, s_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;

  logic [DATA_W-1:0]   mul_x;
  logic [2*DATA_W-1:0] prod;
  logic                cmp;
  logic [DATA_W-1:0]   dividend, divisor;
  logic                load, step, div_done;

  always_comb begin
    mul_x = s_q ? a_q : c_q;
    prod  = {{DATA_W{1'b0}}, mul_x} * {{DATA_W{1'b0}}, b_q};
    cmp   = (prod > (2*DATA_W)'(CMP_THRESH));
    unique case ({s_q, cmp})
      2'b11:   begin dividend = b_q; divisor = c_q; end
      2'b10:   begin dividend = c_q; divisor = b_q; end
      2'b01:   begin dividend = a_q; divisor = b_q; end
      default: begin dividend = b_q; divisor = a_q; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    load      = 1'b0;
    step      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          s_d     = s;
          a_d     = a;
          b_d     = b;
          c_d     = c;
          state_d = SEL;
        end
      end
      SEL: begin
        load    = 1'b1;
        state_d = DIV;
      end
      DIV: begin
        step = 1'b1;
        if (div_done) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  share_div_core u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .step_i     (step),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .done_o     (div_done),
    .quo_o      (y)
`ifdef SHARE_DIV_REM_EN
    ,
    .rem_o      (r)
`endif
  );

endmodule : share_div_seq

`default_nettype wire

// File: tb/tb_share_div_seq.sv
// ============================================================================
// tb_share_div_seq : directed vector table plus backpressure/reset sequences.
// Remainder checks enabled with SHARE_DIV_REM_EN.  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_share_div_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       s = 1'b0;
  logic [7:0] a = '0, b = '0, c = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] y;
  logic [7:0] r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  share_div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
`ifdef SHARE_DIV_REM_EN
    ,
    .r         (r)
`endif
  );

`ifndef SHARE_DIV_REM_EN
  assign r = 8'h00;
`endif

  typedef struct {
    logic       s;
    logic [7:0] a, b, c;
    logic [7:0] exp_y, exp_r;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_r(input string name, input logic [7:0] exp);
`ifdef SHARE_DIV_REM_EN
    chk(name, {8'h00, r}, {8'h00, exp});
`else
    if (exp === 8'hxx) chk(name, {8'h00, r}, 16'h0);
`endif
  endtask

  // Launches one transaction, scrambles inputs while it is in flight and
  // returns once out_valid is seen (or the cycle budget runs out).
  task automatic run_txn(input logic sv, input logic [7:0] av, bv, cv,
                         output int lat);
    @(negedge clk);
    chk("in_ready_before_accept", {15'h0, in_ready}, 16'h1);
    in_valid = 1'b1; s = sv; a = av; b = bv; c = cv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    s = ~sv; a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    end
  endtask

  task automatic release_out;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [7:0] held_y, held_r;

    vecs[0] = '{1'b1,   8'd3,  8'd50,  8'd7,  8'd7,   8'd1};
    vecs[1] = '{1'b1, 8'd255, 8'd255, 8'd16, 8'd15,  8'd15};
    vecs[2] = '{1'b0,   8'd7,   8'd2,  8'd4,  8'd0,   8'd2};
    vecs[3] = '{1'b0, 8'd200,   8'd3,  8'd5, 8'd66,   8'd2};
    vecs[4] = '{1'b1,   8'd1,  8'd20,  8'd0, 8'hFF,  8'd20};
    vecs[5] = '{1'b0,   8'd0,   8'd1,  8'd1, 8'hFF,   8'd1};
    vecs[6] = '{1'b1,   8'd2,   8'd4, 8'd100, 8'd25,  8'd0};
    vecs[7] = '{1'b0,   8'd9, 8'd100,  8'd3,  8'd0,   8'd9};

    #12;
    chk("reset_out_valid", {15'h0, out_valid}, 16'h0);
    chk("reset_y", {8'h0, y}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_in_ready", {15'h0, in_ready}, 16'h1);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].c, lat);
      chk($sformatf("vec%0d_latency", i), 16'(lat), 16'd9);
      chk($sformatf("vec%0d_y", i), {8'h0, y}, {8'h0, vecs[i].exp_y});
      chk_r($sformatf("vec%0d_r", i), vecs[i].exp_r);
      release_out();
      chk($sformatf("vec%0d_out_valid_drop", i), {15'h0, out_valid}, 16'h0);
    end

    // Backpressure: result must hold with the input side closed.
    run_txn(1'b1, 8'd3, 8'd50, 8'd7, lat);
    chk("bp_latency", 16'(lat), 16'd9);
    held_y = 8'd7;
    held_r = 8'd1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      chk($sformatf("bp%0d_out_valid", k), {15'h0, out_valid}, 16'h1);
      chk($sformatf("bp%0d_in_ready", k), {15'h0, in_ready}, 16'h0);
      chk($sformatf("bp%0d_y", k), {8'h0, y}, {8'h0, held_y});
      chk_r($sformatf("bp%0d_r", k), held_r);
    end
    release_out();

    // Reset asserted in the 4th DIV cycle discards the transaction.
    @(negedge clk);
    in_valid = 1'b1; s = 1'b1; a = 8'd255; b = 8'd255; c = 8'd16;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {15'h0, out_valid}, 16'h0);
    chk("midrst_y", {8'h0, y}, 16'h0);
    chk("midrst_in_ready", {15'h0, in_ready}, 16'h1);
    chk_r("midrst_r", 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      chk("midrst_no_stale_valid", {15'h0, out_valid}, 16'h0);
    end

    run_txn(1'b1, 8'd1, 8'd2, 8'd9, lat);
    chk("post_rst_latency", 16'(lat), 16'd9);
    chk("post_rst_y", {8'h0, y}, 16'd4);
    chk_r("post_rst_r", 8'd1);
    release_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_share_div_seq

`default_nettype wire
